if_prefetch: RTL and testbench

- Instruction-fetch front end that sits upstream of decode/execute.
- Owns the PC and issues word requests to an instruction memory port with variable latency.
- Buffers returned instructions, with their PCs, in a small FIFO and presents them over a valid/ready handshake.
- Accepts branch/jump redirects, which flush the buffer and discard any in-flight stale fetch.

---
 rtl/if_pkg.sv | 18 +
 rtl/if_fifo.sv | 71 +++++++
 rtl/if_prefetch.sv | 135 +++++++++++++
 tb/tb_if_prefetch.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch front end: fetch FSM states and the
// buffered {pc, instruction} entry.
package if_pkg;

    localparam int unsigned INST_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_entry_t;

endpackage

// File: rtl/if_fifo.sv
// DEPTH-entry fall-through FIFO of fetched {pc, instruction} entries.
// Flush wins over push and pop; pop on empty and push on full are ignored.
module if_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  if_entry_t                push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output if_entry_t                head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push;
    logic              do_pop;

    always_comb begin
        do_push  = push_i && (count_q != CW'(DEPTH)) && !flush_i;
        do_pop   = pop_i && (count_q != '0) && !flush_i;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage is cleared on reset so the head reads as zero while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: owns the PC, issues one word fetch at a time and
// buffers responses. Define IF_PERF_CNT_EN to add the fetch/stall counters.
//
//   state | meaning
//   IDLE  | may request fetch_pc when the buffer has room
//   WAIT  | request granted, waiting for its response
//   DROP  | redirected while waiting; the response will be discarded
module if_prefetch
    import if_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redir_en,
    input  logic [31:0] redir_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    if_state_e      state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    req_pc_q, req_pc_d;
    logic [CW-1:0]  count;
    logic           fifo_room;
    logic           push;
    logic           pop;
    if_entry_t      push_data;
    if_entry_t      head;

    assign fifo_room = (count != CW'(DEPTH));
    assign push_data = '{pc: req_pc_q, inst: mem_rdata};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        mem_req    = 1'b0;
        push       = 1'b0;
        unique case (state_q)
            IDLE: begin
                mem_req = !rst && fifo_room && !redir_en;
                if (mem_req && mem_gnt) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'(INST_BYTES);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    push    = !redir_en;
                    state_d = IDLE;
                end else if (redir_en) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                // The stale response ends the drop even in a redirect cycle;
                // nothing else is in flight to wait for.
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redir_en) begin
            fetch_pc_d = {redir_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    assign mem_addr   = fetch_pc_q;
    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

    if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (redir_en),
        .count_o     (count),
        .head_o      (head)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_q + 32'(pop);
            stall_cnt_q <= stall_cnt_q + 32'(inst_ready && !inst_valid);
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Self-checking bench for if_prefetch: variable-latency memory model plus a
// scoreboard of expected {pc, inst} entries pushed at grant time.
module tb_if_prefetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redir_en;
    logic [31:0] redir_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    if_prefetch #(
        .DEPTH    (4),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .redir_en   (redir_en),
        .redir_pc   (redir_pc),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .inst_pc    (inst_pc)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    int          n_chk = 0;
    int          n_pass = 0;
    logic [63:0] sbq[$];
    logic [31:0] gnt_log[$];
    logic [31:0] exp_pc;
    bit          pend;
    int          cd;
    logic [31:0] pend_data;
    int          lat = 1;
    int          gnt_stall = 0;
    int          stall_seen = 0;
    int          data_mode = 0;
    int          cyc = 0;
    int          first_gnt_cyc = -1;
    int          first_val_cyc = -1;
    int          pops = 0;
    int          stalls = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [31:0] data_fn(input logic [31:0] a);
        return (data_mode == 0) ? 32'h0000_0013 : (a ^ 32'hDEAD_0000);
    endfunction

    function automatic logic [31:0] gl(input int i);
        return (i < gnt_log.size()) ? gnt_log[i] : 32'hBAD0_BAD0;
    endfunction

    // One clock cycle: entered at a negedge with stimulus inputs set.
    task automatic cycle();
        logic [63:0] e;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (pend) begin
            cd--;
            if (cd == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_data;
            end
        end
        #1;
        if (mem_req) begin
            chk("req_addr", mem_addr, exp_pc);
            chk("one_outstanding", 32'(pend), 32'd0);
            if (gnt_stall > 0) begin
                gnt_stall--;
                stall_seen++;
            end else begin
                mem_gnt = 1'b1;
            end
        end
        #1;
        if (inst_ready && !inst_valid) stalls++;
        if (inst_ready && inst_valid) pops++;
        if (inst_valid && first_val_cyc < 0) first_val_cyc = cyc;
        if (redir_en) begin
            sbq.delete();
            exp_pc = {redir_pc[31:2], 2'b00};
        end else if (inst_valid && inst_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pop", inst_pc, 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                chk("inst_pc", inst_pc, e[63:32]);
                chk("inst", inst, e[31:0]);
            end
        end
        if (mem_gnt) begin
            gnt_log.push_back(mem_addr);
            if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
            pend      = 1'b1;
            cd        = lat;
            pend_data = data_fn(mem_addr);
            sbq.push_back({mem_addr, data_fn(mem_addr)});
            exp_pc    = exp_pc + 32'd4;
        end
        if (mem_rvalid) pend = 1'b0;
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        redir_en   = 1'b0;
        redir_pc   = '0;
        inst_ready = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        repeat (2) @(negedge clk);
        sbq.delete();
        gnt_log.delete();
        pend          = 1'b0;
        cd            = 0;
        exp_pc        = RESET_PC;
        first_gnt_cyc = -1;
        first_val_cyc = -1;
        pops          = 0;
        stalls        = 0;
        rst           = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        int g0;

        do_reset();

        // Back-to-back fetch with 1-cycle memory.
        lat = 1; data_mode = 0; inst_ready = 1'b1;
        repeat (12) cycle();
        chk("t1_addr0", gl(0), 32'h0);
        chk("t1_addr1", gl(1), 32'h4);
        chk("t1_addr2", gl(2), 32'h8);
        chk("t1_latency", 32'(first_val_cyc - first_gnt_cyc), 32'd2);

        // Consumer stalled: buffer fills to DEPTH, then requests stop.
        inst_ready = 1'b0; data_mode = 1;
        repeat (20) cycle();
        chk("t2_buffered", 32'(sbq.size()), 32'd4);
        chk("t2_req_full", 32'(mem_req), 32'd0);
        chk("t2_valid", 32'(inst_valid), 32'd1);
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        #1;
        chk("t2_req_after_pop", 32'(mem_req), 32'd1);
        inst_ready = 1'b1;
        repeat (10) cycle();

        // Redirect while waiting on a slow response.
        lat = 4;
        k = 0;
        while (!(pend && cd == 4) && k < 30) begin cycle(); k++; end
        if (k >= 30) chk("t3_timeout", 32'd0, 32'd1);
        g0 = gnt_log.size();
        redir_en = 1'b1; redir_pc = 32'h0000_0103;
        cycle();
        redir_en = 1'b0;
        repeat (14) cycle();
        chk("t3_target", gl(g0), 32'h100);
        chk("t3_next", gl(g0 + 1), 32'h104);

        // Redirect coinciding with a response and a pop.
        lat = 3; inst_ready = 1'b0;
        k = 0;
        while (!(pend && cd == 1 && sbq.size() >= 3) && k < 60) begin cycle(); k++; end
        if (k >= 60) chk("t4_timeout", 32'd0, 32'd1);
        inst_ready = 1'b1; redir_en = 1'b1; redir_pc = 32'h0000_0200;
        chk("t4_pre_valid", 32'(inst_valid), 32'd1);
        g0 = gnt_log.size();
        cycle();
        redir_en = 1'b0; inst_ready = 1'b0;
        #1;
        chk("t4_empty", 32'(inst_valid), 32'd0);
        inst_ready = 1'b1;
        repeat (10) cycle();
        chk("t4_target", gl(g0), 32'h200);

        // Grant withheld, then reset asserted in WAIT.
        inst_ready = 1'b0; lat = 1;
        repeat (4) cycle();
        lat = 3; stall_seen = 0; gnt_stall = 5;
        k = 0;
        while (!(pend && cd == 3) && k < 30) begin cycle(); k++; end
        if (k >= 30) chk("t5_timeout", 32'd0, 32'd1);
        chk("t5_stalled", 32'(stall_seen), 32'd5);
        chk("t5_pre_valid", 32'(inst_valid), 32'd1);
        do_reset();
        inst_ready = 1'b1; lat = 1;
        repeat (8) cycle();
        chk("t5_restart", gl(0), RESET_PC);

        // Address wrap at the top of the address space.
        redir_en = 1'b1; redir_pc = 32'hFFFF_FFFE;
        cycle();
        redir_en = 1'b0;
        g0 = gnt_log.size();
        repeat (10) cycle();
        chk("t6_top", gl(g0), 32'hFFFF_FFFC);
        chk("t6_wrap", gl(g0 + 1), 32'h0);

`ifdef IF_PERF_CNT_EN
        do_reset();
        inst_ready = 1'b1; lat = 2;
        k = 0;
        while (pops < 10 && k < 200) begin cycle(); k++; end
        inst_ready = 1'b0;
        #1;
        chk("perf_fetch", fetch_cnt, 32'd10);
        chk("perf_stall", stall_cnt, 32'(stalls));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
